// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter sharing one fixed-latency memory between instruction fetch and data access
module mem_arbiter #(
   parameter int LAT        = 2,
   parameter int STARVE_MAX = 3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        I_Req,
   input  logic [31:0] I_Addr,
   output logic        I_Ack,
   output logic [31:0] I_Rdata,
   input  logic        D_Req,
   input  logic        D_We,
   input  logic [31:0] D_Addr,
   input  logic [31:0] D_Wdata,
   input  logic [3:0]  D_Be,
   output logic        D_Ack,
   output logic [31:0] D_Rdata,
   output logic        M_En,
   output logic        M_We,
   output logic [31:0] M_Addr,
   output logic [31:0] M_Wdata,
   output logic [3:0]  M_Be,
   input  logic [31:0] M_Rdata,
   output logic        Busy
);
   localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

   state_t        state, state_nx;
   logic          own_d, we_q;
   logic [31:0]   addr_q, wdata_q;
   logic [3:0]    be_q;
   logic [CW-1:0] cnt;
   logic [SW-1:0] starve;
   logic          grant_any, grant_d, grant, starved, cap;

   assign grant_any = I_Req | D_Req;
   assign starved   = I_Req & (starve == SW'(STARVE_MAX));
   assign grant_d   = D_Req & ~starved;
   assign grant     = (state == IDLE) & grant_any;
   assign cap       = (state == WAIT) & (cnt == '0);

   assign M_Addr  = addr_q;
   assign M_Wdata = wdata_q;
   assign M_Be    = be_q;

   // state register
   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   // next-state: one access cycle, reads wait out the memory latency, then a one-cycle ack
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = grant_any ? ACCESS : IDLE;
         ACCESS:  state_nx = we_q ? RESP : WAIT;
         WAIT:    state_nx = (cnt == '0) ? RESP : WAIT;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // outputs decoded from the state and the latched owner
   always_comb begin
      M_En  = (state == ACCESS);
      M_We  = (state == ACCESS) & we_q;
      I_Ack = (state == RESP) & ~own_d;
      D_Ack = (state == RESP) & own_d;
      Busy  = (state != IDLE);
   end

   // latch the winning request so the requester may change or drop it afterwards
   always_ff @(posedge Clk) begin
      if (Reset) begin
         own_d   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (grant) begin
         own_d   <= grant_d;
         we_q    <= grant_d & D_We;
         addr_q  <= grant_d ? D_Addr : I_Addr;
         wdata_q <= grant_d ? D_Wdata : wdata_q;
         be_q    <= (grant_d & D_We) ? D_Be : 4'hF;
      end
   end

   // count consecutive data grants that made a waiting fetch lose
   always_ff @(posedge Clk) begin
      if (Reset)
         starve <= '0;
      else if (grant)
         starve <= (grant_d & I_Req) ? ((starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1) : '0;
   end

   // memory latency countdown for reads
   always_ff @(posedge Clk) begin
      if (Reset)
         cnt <= '0;
      else if (state == ACCESS)
         cnt <= CW'(LAT - 1);
      else if ((state == WAIT) && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   // capture read data into the owner's register; it holds until that port's next read
   always_ff @(posedge Clk) begin
      if (Reset) begin
         I_Rdata <= '0;
         D_Rdata <= '0;
      end else if (cap) begin
         if (own_d) D_Rdata <= M_Rdata;
         else       I_Rdata <= M_Rdata;
      end
   end
endmodule
